// File: rtl/extremum_finder.sv
// rtl/extremum_finder.sv - windowed signed min/max monitor on an AXI-Stream sample path
// Optional midpoint output EF_center is enabled by defining EXTREMUM_FINDER_CENTER_EN.
module extremum_finder #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int RESULT_WIDTH     = 16
) (
  input  logic                          SYS_aclk,
  input  logic                          SYS_areset,
  input  logic [4:0]                    EF_log_count,
  input  logic [2:0]                    EF_shift,
  input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic                          S_AXIS_tvalid,
  output logic                          S_AXIS_tready,
`ifdef EXTREMUM_FINDER_CENTER_EN
  output logic [RESULT_WIDTH-1:0]       EF_center,
`endif
  output logic [2*RESULT_WIDTH-1:0]     M_AXIS_tdata,
  output logic                          M_AXIS_tvalid
);

  localparam int DW = AXIS_TDATA_WIDTH;
  localparam int RW = RESULT_WIDTH;

  // Clamp bounds carried at DW+1 bits so the center path can share them.
  localparam logic signed [DW:0] SAT_HI = $signed({{(DW-RW+2){1'b0}}, {(RW-1){1'b1}}});
  localparam logic signed [DW:0] SAT_LO = $signed({{(DW-RW+2){1'b1}}, {(RW-1){1'b0}}});

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [30:0]            r_count;
  logic [30:0]            r_last;
  logic signed [DW-1:0]   r_min;
  logic signed [DW-1:0]   r_max;
  logic [2*RW-1:0]        r_tdata;
  logic                   r_tvalid;

  logic                   w_start;
  logic                   w_update;
  logic                   w_end;
  logic signed [DW-1:0]   w_sample;
  logic signed [DW-1:0]   w_lo;
  logic signed [DW-1:0]   w_hi;
  logic signed [DW-1:0]   w_max_sh;
  logic signed [DW-1:0]   w_min_sh;
  logic [30:0]            w_last_new;

  function automatic logic [RW-1:0] f_sat(input logic signed [DW:0] v);
    if (v > SAT_HI)
      return SAT_HI[RW-1:0];
    else if (v < SAT_LO)
      return SAT_LO[RW-1:0];
    else
      return v[RW-1:0];
  endfunction

  assign S_AXIS_tready = 1'b1;
  assign M_AXIS_tdata  = r_tdata;
  assign M_AXIS_tvalid = r_tvalid;

  assign w_sample   = $signed(S_AXIS_tdata);
  assign w_lo       = (w_sample < r_min) ? w_sample : r_min;
  assign w_hi       = (w_sample > r_max) ? w_sample : r_max;
  assign w_max_sh   = w_hi >>> EF_shift;
  assign w_min_sh   = w_lo >>> EF_shift;
  // N-1 for the incoming window; wraps to all ones for N = 2^31.
  assign w_last_new = (31'd1 << EF_log_count) - 31'd1;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_update     = 1'b0;
    w_end        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (EF_log_count != 5'd0) begin
          w_state_next = ST_RUN;
          w_start      = S_AXIS_tvalid;
        end
      end
      ST_RUN: begin
        // Between windows a zero log_count parks the block; mid-window it is ignored.
        if (r_count == 31'd0) begin
          if (EF_log_count == 5'd0)
            w_state_next = ST_IDLE;
          else
            w_start = S_AXIS_tvalid;
        end else if (S_AXIS_tvalid) begin
          w_update = 1'b1;
          w_end    = (r_count == r_last);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_areset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_last   <= '0;
      r_min    <= '0;
      r_max    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_tvalid <= w_end;
      if (w_start) begin
        r_min   <= w_sample;
        r_max   <= w_sample;
        r_count <= 31'd1;
        r_last  <= w_last_new;
      end else if (w_update) begin
        r_min   <= w_lo;
        r_max   <= w_hi;
        r_count <= w_end ? 31'd0 : r_count + 31'd1;
      end
      if (w_end)
        r_tdata <= {f_sat({w_max_sh[DW-1], w_max_sh}), f_sat({w_min_sh[DW-1], w_min_sh})};
    end
  end

`ifdef EXTREMUM_FINDER_CENTER_EN
  logic signed [DW:0] w_sum;
  logic signed [DW:0] w_center_sh;
  logic [RW-1:0]      r_center;

  // One guard bit keeps max+min exact before halving.
  assign w_sum       = $signed({w_hi[DW-1], w_hi}) + $signed({w_lo[DW-1], w_lo});
  assign w_center_sh = (w_sum >>> 1) >>> EF_shift;
  assign EF_center   = r_center;

  always_ff @(posedge SYS_aclk) begin
    if (SYS_areset)
      r_center <= '0;
    else if (w_end)
      r_center <= f_sat(w_center_sh);
  end
`endif

endmodule

// File: tb/tb_extremum_finder.sv
// tb/tb_extremum_finder.sv - directed self-checking bench for extremum_finder
module tb_extremum_finder;

  logic        clk;
  logic        rst;
  logic [4:0]  log_count;
  logic [2:0]  shift;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
`ifdef EXTREMUM_FINDER_CENTER_EN
  logic [15:0] center;
`endif

  int checks = 0;
  int errors = 0;

  extremum_finder dut (
    .SYS_aclk      (clk),
    .SYS_areset    (rst),
    .EF_log_count  (log_count),
    .EF_shift      (shift),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tready (s_tready),
`ifdef EXTREMUM_FINDER_CENTER_EN
    .EF_center     (center),
`endif
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tvalid (m_tvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one accepted sample, then sample outputs 1ns after the edge.
  task automatic send(input int v, input logic exp_valid, input string tag);
    s_tdata  = v;
    s_tvalid = 1'b1;
    @(posedge clk); #1;
    chk(tag, {31'd0, m_tvalid}, {31'd0, exp_valid});
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input logic exp_valid, input string tag);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    chk(tag, {31'd0, m_tvalid}, {31'd0, exp_valid});
  endtask

  initial begin
    rst = 1'b1; log_count = 5'd3; shift = 3'd0; s_tdata = 32'd0; s_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tready", {31'd0, s_tready}, 32'd1);

    // Disabled: no window is ever formed.
    rst = 1'b0; log_count = 5'd0; s_tvalid = 1'b0;
    @(posedge clk); #1;
    send(-20, 1'b0, "dis_0"); send(-10, 1'b0, "dis_1"); send(10, 1'b0, "dis_2");
    send(20, 1'b0, "dis_3"); send(10, 1'b0, "dis_4");
    chk("dis_tdata", m_tdata, 32'd0);

    // First 8-sample window, strobe right after 8th sample.
    log_count = 5'd3; shift = 3'd0;
    send(-10, 1'b0, "w1_s0"); send(-30, 1'b0, "w1_s1"); send(-40, 1'b0, "w1_s2");
    send(-20, 1'b0, "w1_s3"); send(10, 1'b0, "w1_s4"); send(20, 1'b0, "w1_s5");
    send(30, 1'b0, "w1_s6"); send(40, 1'b1, "w1_s7");
    chk("w1_tdata", m_tdata, 32'h0028FFD8);
    idle(1'b0, "w1_one_cycle");
    chk("w1_hold", m_tdata, 32'h0028FFD8);

    // Second window with a 3-clock tvalid gap.
    send(50, 1'b0, "w2_s0"); send(60, 1'b0, "w2_s1"); send(50, 1'b0, "w2_s2");
    send(40, 1'b0, "w2_s3");
    idle(1'b0, "w2_gap0"); idle(1'b0, "w2_gap1"); idle(1'b0, "w2_gap2");
    send(40, 1'b0, "w2_s4"); send(45, 1'b0, "w2_s5"); send(55, 1'b0, "w2_s6");
    send(50, 1'b1, "w2_s7");
    chk("w2_tdata", m_tdata, 32'h003C0028);

    // N=2 back-to-back windows: shift then saturation.
    log_count = 5'd1; shift = 3'd2;
    send(-100000, 1'b0, "sh2_s0"); send(100000, 1'b1, "sh2_s1");
    chk("sh2_tdata", m_tdata, 32'h61A89E58);
    shift = 3'd0;
    send(-100000, 1'b0, "sat_s0"); send(100000, 1'b1, "sat_s1");
    chk("sat_tdata", m_tdata, 32'h7FFF8000);

    // Reset mid-window drops the partial window and restarts the count.
    log_count = 5'd3;
    send(1, 1'b0, "rw_p0"); send(2, 1'b0, "rw_p1"); send(3, 1'b0, "rw_p2");
    send(4, 1'b0, "rw_p3"); send(5, 1'b0, "rw_p4");
    rst = 1'b1;
    idle(1'b0, "rw_rst_tvalid");
    chk("rw_rst_tdata", m_tdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      send(100 + i, (i == 7), $sformatf("rw_s%0d", i));
    chk("rw_tdata", m_tdata, 32'h006B0064);

    // log_count dropped to 0 mid-window: window of 4 still completes, then idle.
    log_count = 5'd2;
    send(7, 1'b0, "lc_s0"); send(-3, 1'b0, "lc_s1");
    log_count = 5'd0;
    send(5, 1'b0, "lc_s2"); send(2, 1'b1, "lc_s3");
    chk("lc_tdata", m_tdata, 32'h0007FFFD);
    for (int i = 0; i < 6; i++)
      send(1000, 1'b0, $sformatf("lc_idle%0d", i));
    chk("lc_hold", m_tdata, 32'h0007FFFD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
